fir_pcfg_filter: RTL and testbench

- Parametrised successor to the fixed 33-tap, 16-bit FIR with a register-configured coefficient bank.
- Generic in tap count, sample width and output scaling.
- Adds valid-qualified input, double-buffered (shadow/active) coefficients with glitch-free commit, round/saturate output stage, bypass mode, sticky overflow flag, and a Wishbone slave with address error reporting.
- Sits between the I2C-to-Wishbone master and the sample path; the 64-bit testvec feeds the logic analyser.

---
 rtl/fir_pcfg_filter.sv | 205 ++++++++++++++++++++
 tb/tb_fir_pcfg_filter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_pcfg_filter.sv
// Parametrised FIR with double-buffered Wishbone-configured coefficients,
// three-stage multiply / sum / round-saturate pipeline, bypass and sticky overflow.
module fir_pcfg_filter #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 33,
  parameter int OUT_SHIFT = 15,
  parameter int WB_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic [WB_ADDR_W-1:0] wb_adr_i,
  input  logic [15:0]          wb_dat_i,
  output logic [15:0]          wb_dat_o,
  input  logic                 wb_we_i,
  input  logic [1:0]           wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [63:0]          testvec
);
  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + $clog2(TAPS);
  localparam logic signed [AW:0] RND  = (OUT_SHIFT == 0) ? '0 :
                                        (AW+1)'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0);
  localparam logic signed [AW:0] MAXV = (AW+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [AW:0] MINV = ~MAXV;
  localparam logic [WB_ADDR_W-1:0] A_CTRL = WB_ADDR_W'(8'hF0);
  localparam logic [WB_ADDR_W-1:0] A_STAT = WB_ADDR_W'(8'hF1);
  localparam logic [WB_ADDR_W-1:0] A_TVSL = WB_ADDR_W'(8'hF2);

  function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] a);
    logic signed [AW:0] t;
    t = (AW+1)'(a) + RND;
    return t >>> OUT_SHIFT;
  endfunction

  function automatic logic out_of_range(input logic signed [AW:0] r);
    return (r > MAXV) || (r < MINV);
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [AW:0] r, input logic en);
    if (en && (r > MAXV)) return MAXV[DATA_W-1:0];
    if (en && (r < MINV)) return MINV[DATA_W-1:0];
    return r[DATA_W-1:0];
  endfunction

  function automatic logic signed [COEF_W-1:0] merge(input logic signed [COEF_W-1:0] old,
                                                    input logic [15:0] d, input logic [1:0] sel);
    logic [15:0] w;
    w = 16'(old);
    if (sel[0]) w[7:0]  = d[7:0];
    if (sel[1]) w[15:8] = d[15:8];
    return w[COEF_W-1:0];
  endfunction

  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [DATA_W-1:0] x      [TAPS];
  logic signed [DATA_W-1:0] x_next [TAPS];
  logic signed [PW-1:0]     prod_p0 [TAPS];
  logic signed [AW-1:0]     sum_p0, acc_p1;
  logic signed [AW:0]       r_p1;
  logic signed [DATA_W-1:0] in_s, bdat_p0, bdat_p1, out_p2;
  logic                     vld_p0, vld_p1, vld_p2, byp_p0, byp_p1;
  logic                     bypass, sat_en, pending, ovf;
  logic [15:0]              tvsel, rd_data;
  logic [TAPS-1:0]          coef_hit;
  logic                     hit_ctrl, hit_stat, hit_tv, addr_ok;
  logic                     access, wr, commit_wr, copy, ovf_clr;

  assign in_s      = in_data;
  assign out_data  = out_p2;
  assign out_valid = vld_p2;

  // A new access is only accepted once the previous ack/err pulse has gone.
  assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wr        = access & wb_we_i;
  assign commit_wr = wr & hit_ctrl & wb_dat_i[0];
  assign ovf_clr   = wr & hit_stat & wb_dat_i[1];
  assign copy      = pending & ~in_valid;

  always_comb begin
    coef_hit = '0;
    rd_data  = '0;
    addr_ok  = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      if (wb_adr_i == WB_ADDR_W'(k)) begin
        coef_hit[k] = 1'b1;
        addr_ok     = 1'b1;
        rd_data     = 16'(shadow[k]);
      end
    end
    hit_ctrl = (wb_adr_i == A_CTRL);
    hit_stat = (wb_adr_i == A_STAT);
    hit_tv   = (wb_adr_i == A_TVSL);
    if (hit_ctrl) begin
      addr_ok = 1'b1;
      rd_data = {13'd0, sat_en, bypass, 1'b0};
    end
    if (hit_stat) begin
      addr_ok = 1'b1;
      rd_data = {14'd0, ovf, pending};
    end
    if (hit_tv) begin
      addr_ok = 1'b1;
      rd_data = tvsel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      bypass   <= 1'b0;
      sat_en   <= 1'b0;
      tvsel    <= '0;
      pending  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      wb_ack_o <= access & addr_ok;
      wb_err_o <= access & ~addr_ok;
      wb_dat_o <= access ? rd_data : '0;
      for (int k = 0; k < TAPS; k++) begin
        if (wr && coef_hit[k]) shadow[k] <= merge(shadow[k], wb_dat_i, wb_sel_i);
        if (copy) active[k] <= shadow[k];
      end
      if (wr && hit_ctrl) begin
        bypass <= wb_dat_i[1];
        sat_en <= wb_dat_i[2];
      end
      if (wr && hit_tv) tvsel <= wb_dat_i;
      // A commit landing on the copy edge must survive for the next idle cycle.
      pending <= commit_wr | (pending & ~copy);
    end
  end

  always_comb begin
    x_next[0] = in_s;
    for (int k = 1; k < TAPS; k++) x_next[k] = x[k-1];
  end

  always_comb begin
    sum_p0 = '0;
    for (int k = 0; k < TAPS; k++) sum_p0 = sum_p0 + AW'(prod_p0[k]);
  end

  assign r_p1 = round_shift(acc_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      byp_p0  <= 1'b0;
      byp_p1  <= 1'b0;
      bdat_p0 <= '0;
      bdat_p1 <= '0;
      acc_p1  <= '0;
      out_p2  <= '0;
      ovf     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x[k]       <= '0;
        prod_p0[k] <= '0;
      end
    end else begin
      // S1: advance delay line and register products
      vld_p0 <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < TAPS; k++) begin
          x[k]       <= x_next[k];
          prod_p0[k] <= PW'(x_next[k]) * PW'(active[k]);
        end
        byp_p0  <= bypass;
        bdat_p0 <= in_s;
      end
      // S2: accumulate
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        acc_p1  <= sum_p0;
        byp_p1  <= byp_p0;
        bdat_p1 <= bdat_p0;
      end
      // S3: round, saturate or wrap, flag overflow
      vld_p2 <= vld_p1;
      if (vld_p1) out_p2 <= byp_p1 ? bdat_p1 : saturate(r_p1, sat_en);
      ovf <= (vld_p1 & ~byp_p1 & out_of_range(r_p1)) | (ovf & ~ovf_clr);
    end
  end

  assign testvec = (tvsel != 16'd0) ?
    {out_valid, in_valid, pending, ovf, bypass, sat_en, 2'd0, 8'd0,
     16'(in_s), 16'(out_p2), 16'(acc_p1)} :
    {10'd0, wb_we_i, wb_stb_i, wb_ack_o, wb_err_o, wb_cyc_i, wb_sel_i,
     8'(wb_adr_i), wb_dat_o, wb_dat_i, 7'd0};
endmodule

// File: tb/tb_fir_pcfg_filter.sv
// Scoreboard bench for fir_pcfg_filter: a behavioural model predicts every output
// sample and its cycle; register reads are compared against fixed expectations.
module tb_fir_pcfg_filter;
  localparam int TAPS = 33;

  logic        clk = 0, rst = 1;
  logic        in_valid = 0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0, wb_dat_o;
  logic        wb_we_i = 0, wb_stb_i = 0, wb_cyc_i = 0, wb_ack_o, wb_err_o;
  logic [1:0]  wb_sel_i = '0;
  logic [63:0] testvec;

  fir_pcfg_filter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .testvec(testvec)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct { logic [15:0] val; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  longint m_x[TAPS], m_act[TAPS], m_shadow[TAPS];
  bit m_pending = 0, m_ovf = 0, m_byp = 0, m_sat = 0;
  bit stream_on = 0;
  logic [15:0] stream_val = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_x[k] = 0; m_act[k] = 0; m_shadow[k] = 0;
    end
    m_pending = 0; m_ovf = 0; m_byp = 0; m_sat = 0;
  endtask

  task automatic push_sample(input logic [15:0] v);
    longint acc, r;
    logic [15:0] e;
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = longint'($signed(v));
    if (m_byp) e = v;
    else begin
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += m_x[k] * m_act[k];
      r = (acc + 16384) >>> 15;
      if (r > 32767 || r < -32768) m_ovf = 1;
      if (m_sat && r > 32767) e = 16'h7FFF;
      else if (m_sat && r < -32768) e = 16'h8000;
      else e = r[15:0];
    end
    sbq.push_back('{e, cyc_n + 3});
  endtask

  task automatic model_write(input logic [7:0] adr, input logic [15:0] d, input logic [1:0] sel);
    logic [15:0] w;
    if (adr < TAPS) begin
      w = m_shadow[adr][15:0];
      if (sel[0]) w[7:0] = d[7:0];
      if (sel[1]) w[15:8] = d[15:8];
      m_shadow[adr] = longint'($signed(w));
    end else if (adr == 8'hF0) begin
      m_byp = d[1]; m_sat = d[2];
      if (d[0]) m_pending = 1;
    end else if (adr == 8'hF1) begin
      if (d[1]) m_ovf = 0;
    end
  endtask

  // One clock: inputs for the next edge are driven 1 time unit after this edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (stream_on) begin
      in_valid = 1; in_data = stream_val;
      push_sample(stream_val);
    end else begin
      in_valid = 0;
      if (m_pending) begin
        m_act = m_shadow; m_pending = 0;
      end
    end
  endtask

  task automatic send(input logic [15:0] v);
    bit s;
    logic [15:0] sv;
    s = stream_on; sv = stream_val;
    stream_on = 1; stream_val = v;
    tick();
    stream_on = s; stream_val = sv;
  endtask

  task automatic drain();
    repeat (8) tick();
    check_val("drain_empty", 64'(sbq.size()), 0);
  endtask

  task automatic wb_xfer(input bit we, input logic [7:0] adr, input logic [15:0] dat,
                         input logic [1:0] sel, output logic [15:0] rd, output bit ack, output bit err);
    bit done;
    done = 0; rd = '0; ack = 0; err = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    if (we) model_write(adr, dat, sel);
    for (int i = 0; i < 4 && !done; i++) begin
      tick();
      if (wb_ack_o || wb_err_o) begin
        ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o; done = 1;
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    if (!done) check_val("wb_timeout", 0, 1);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [15:0] dat);
    logic [15:0] rd; bit ack, err;
    wb_xfer(1, adr, dat, 2'b11, rd, ack, err);
    if (!ack || err) check_val("wr_ack", {ack, err}, 2'b10);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] adr, input logic [15:0] exp);
    logic [15:0] rd; bit ack, err;
    wb_xfer(0, adr, 16'h0, 2'b11, rd, ack, err);
    check_val(tag, {ack, err, rd}, {2'b10, exp});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sbq.size() == 0) check_val("unexp_out", {48'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        mon_e = sbq.pop_front();
        check_val("out_data", out_data, mon_e.val);
        check_val("out_lat", cyc_n, mon_e.cyc);
      end
    end
  end

  initial begin
    logic [15:0] rd; bit ack, err;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_outs", {out_valid, out_data, wb_ack_o, wb_err_o, wb_dat_o}, '0);
    check_val("rst_tv", testvec, '0);
    rst = 0;
    tick();
    rd_chk("rst_ctrl", 8'hF0, 16'h0000);
    rd_chk("rst_stat", 8'hF1, 16'h0000);
    rd_chk("rst_coef3", 8'h03, 16'h0000);

    // impulse through coefficient 3
    wr(8'h03, 16'h4000);
    wr(8'hF0, 16'h0001);
    tick(); tick();
    rd_chk("imp_stat", 8'hF1, 16'h0000);
    rd_chk("imp_ctrl", 8'hF0, 16'h0000);
    send(16'h7FFF);
    repeat (6) send(16'h0000);
    drain();

    // commit while streaming continuously
    stream_on = 1; stream_val = 16'h1000;
    wr(8'h00, 16'h2000);
    wr(8'h03, 16'h0000);
    wr(8'hF0, 16'h0001);
    rd_chk("cm_pend", 8'hF1, 16'h0001);
    repeat (3) tick();
    stream_on = 0;
    tick(); tick();
    rd_chk("cm_done", 8'hF1, 16'h0000);
    send(16'h1000);
    drain();

    // saturation and wrap with all taps at full scale
    for (int k = 0; k < TAPS; k++) wr(8'(k), 16'h7FFF);
    wr(8'hF0, 16'h0005);
    tick(); tick();
    repeat (40) send(16'h7FFF);
    drain();
    rd_chk("sat_ovf", 8'hF1, 16'h0002);
    repeat (40) send(16'h8000);
    drain();
    wr(8'hF1, 16'h0002);
    rd_chk("ovf_w1c", 8'hF1, 16'h0000);
    wr(8'hF0, 16'h0000);
    repeat (40) send(16'h7FFF);
    drain();
    rd_chk("wrap_ovf", 8'hF1, 16'h0002);
    wr(8'hF1, 16'h0002);

    // bypass leaves overflow alone
    wr(8'hF0, 16'h0002);
    send(16'h1234);
    send(16'hFEDC);
    drain();
    rd_chk("byp_stat", 8'hF1, 16'h0000);

    // bus errors and byte enables
    wb_xfer(0, 8'h50, 16'h0, 2'b11, rd, ack, err);
    check_val("err_rd", {ack, err, rd}, {2'b01, 16'h0});
    tick();
    check_val("err_pulse", {wb_ack_o, wb_err_o}, 2'b00);
    wb_xfer(1, 8'hF5, 16'hFFFF, 2'b11, rd, ack, err);
    check_val("err_wr", {ack, err}, 2'b01);
    rd_chk("err_noside", 8'hF0, 16'h0002);
    wr(8'h01, 16'h1111);
    wb_xfer(1, 8'h01, 16'hABCD, 2'b01, rd, ack, err);
    rd_chk("sel_lo", 8'h01, 16'h11CD);

    // logic-analyser vector in both selections
    wr(8'hF2, 16'h0001);
    wr(8'hF0, 16'h0006);
    tick();
    in_data = 16'h5A5A;
    #1;
    check_val("tv_flags", testvec[63:56], 8'h0C);
    check_val("tv_in", testvec[47:32], 16'h5A5A);
    wr(8'hF2, 16'h0000);
    tick();
    wb_adr_i = 8'h12; wb_dat_i = 16'h5678;
    #1;
    check_val("tv_bus", testvec, (64'(8'h12) << 39) | (64'(16'h5678) << 7));
    wb_adr_i = '0; wb_dat_i = '0;

    // reset with samples and a write in flight
    wr(8'hF0, 16'h0000);
    wr(8'h00, 16'h4000);
    wr(8'hF0, 16'h0001);
    tick(); tick();
    send(16'h0100);
    send(16'h0200);
    tick();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 8'h02; wb_dat_i = 16'h7777; wb_sel_i = 2'b11;
    rst = 1;
    #1;
    check_val("mrst_outs", {out_valid, wb_ack_o, wb_err_o, wb_dat_o}, '0);
    sbq.delete();
    model_reset();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    tick(); tick();
    check_val("mrst_hold", {out_valid, wb_ack_o, wb_err_o}, 3'b000);
    rst = 0;
    rd_chk("mrst_c0", 8'h00, 16'h0000);
    rd_chk("mrst_c2", 8'h02, 16'h0000);
    rd_chk("mrst_stat", 8'hF1, 16'h0000);
    send(16'h7FFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
